// File: rtl/atm_pkg.sv
// -----------------------------------------------------------------------------
// atm_pkg
// Shared types for the ATM session controller: FSM state encoding, keypad
// operation codes and the error codes reported on err_code.
// No ports; imported by atm_session_ctrl and atm_inactivity_timer.
// -----------------------------------------------------------------------------
package atm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_PSW = 2'd1,
        ST_MENU     = 2'd2,
        ST_EJECT    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_INQUIRY  = 2'b00,
        OP_WITHDRAW = 2'b01,
        OP_DEPOSIT  = 2'b10,
        OP_END      = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_BAD_CARD = 3'd1,
        ERR_LOCKED   = 3'd2,
        ERR_INSUFF   = 3'd3,
        ERR_LIMIT    = 3'd4,
        ERR_OVF      = 3'd5,
        ERR_TIMEOUT  = 3'd6,
        ERR_ZERO_AMT = 3'd7
    } err_e;

endpackage

// File: rtl/atm_inactivity_timer.sv
// -----------------------------------------------------------------------------
// atm_inactivity_timer
// Counts cycles while enabled and flags when the count reaches threshold.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   enable      count only while high (count held at zero otherwise)
//   restart     clear the count this cycle
//   threshold   cycles until timeout; 0 disables the timer
//   timeout     combinational: the count will reach threshold at the next edge
// -----------------------------------------------------------------------------
module atm_inactivity_timer #(
    parameter int TMR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             restart,
    input  logic [TMR_W-1:0] threshold,
    output logic             timeout
);

    logic [TMR_W-1:0] count_q, count_d;
    logic [TMR_W:0]   count_inc;

    // One extra bit so the comparison cannot wrap at the top of the range.
    assign count_inc = {1'b0, count_q} + (TMR_W+1)'(1);

    // Timeout is not gated by restart: the controller decides priority, and
    // keeping restart out of this path avoids a loop through next-state logic.
    assign timeout = enable && (threshold != '0) && (count_inc >= {1'b0, threshold});

    always_comb begin
        count_d = count_q;
        if (restart || !enable) begin
            count_d = '0;
        end else if (count_q != '1) begin
            count_d = count_inc[TMR_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/atm_session_ctrl.sv
// -----------------------------------------------------------------------------
// atm_session_ctrl
// Single-session ATM controller: account table (PIN, balance, lock bit),
// PIN retry/lock handling, withdraw/deposit datapath with per-session limit,
// and inactivity eject.
// Ports:
//   clk, rst                               clock, asynchronous active-high reset
//   prog_en/prog_idx/prog_psw/prog_bal     table programming (IDLE only)
//   card_in/card_number                    card insertion pulse and id
//   psw_valid/password_input               PIN entry pulse and value
//   op_valid/operation/value               menu operation pulse, code, amount
//   threshold                              inactivity cycles (0 = off)
//   busy                                   state != IDLE
//   card_out, op_done, error, wrong_psw    registered 1-cycle pulses
//   err_code                               error cause, valid with error
//   balance                                current session balance
//   locked                                 session account is locked
// -----------------------------------------------------------------------------
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int NUM_ACCTS     = 8,
    parameter int CARD_W        = 6,
    parameter int PSW_W         = 16,
    parameter int BAL_W         = 20,
    parameter int MAX_TRIES     = 3,
    parameter int SESSION_LIMIT = 5000,
    parameter int TMR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_en,
    input  logic [CARD_W-1:0] prog_idx,
    input  logic [PSW_W-1:0]  prog_psw,
    input  logic [BAL_W-1:0]  prog_bal,
    input  logic              card_in,
    input  logic [CARD_W-1:0] card_number,
    input  logic              psw_valid,
    input  logic [PSW_W-1:0]  password_input,
    input  logic              op_valid,
    input  logic [1:0]        operation,
    input  logic [BAL_W-1:0]  value,
    input  logic [TMR_W-1:0]  threshold,
    output logic              busy,
    output logic              card_out,
    output logic              op_done,
    output logic [BAL_W-1:0]  balance,
    output logic              error,
    output logic [2:0]        err_code,
    output logic              wrong_psw,
    output logic              locked
);

    localparam int IDX_W = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [CARD_W:0]  NUM_ACCTS_C = (CARD_W+1)'(NUM_ACCTS);
    localparam logic [BAL_W+1:0] LIMIT_C     = (BAL_W+2)'(SESSION_LIMIT);
    localparam logic [TRY_W-1:0] MAX_TRIES_C = TRY_W'(MAX_TRIES);

    // Session total is one bit wider than an amount; widen once more for the check.
    function automatic logic limit_exceeded(input logic [BAL_W:0] total, input logic [BAL_W-1:0] amt);
        logic [BAL_W+1:0] sum;
        sum = {1'b0, total} + {2'b00, amt};
        return sum > LIMIT_C;
    endfunction

    function automatic logic add_overflows(input logic [BAL_W-1:0] a, input logic [BAL_W-1:0] b);
        logic [BAL_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[BAL_W];
    endfunction

    state_e               state_q, state_d;
    logic [PSW_W-1:0]     psw_tab_q [NUM_ACCTS];
    logic [PSW_W-1:0]     psw_tab_d [NUM_ACCTS];
    logic [BAL_W-1:0]     bal_tab_q [NUM_ACCTS];
    logic [BAL_W-1:0]     bal_tab_d [NUM_ACCTS];
    logic [NUM_ACCTS-1:0] lock_tab_q, lock_tab_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [TRY_W-1:0]     tries_q, tries_d;
    logic [BAL_W:0]       total_q, total_d;
    logic [BAL_W-1:0]     balance_q, balance_d;
    logic                 card_out_q, card_out_d;
    logic                 op_done_q, op_done_d;
    logic                 error_q, error_d;
    logic [2:0]           err_code_q, err_code_d;
    logic                 wrong_psw_q, wrong_psw_d;
    logic                 locked_q, locked_d;

    logic             card_ok, prog_ok, card_reject;
    logic [IDX_W-1:0] card_idx, prog_tab_idx;
    logic             psw_acc, op_acc, psw_match, last_try;
    logic [TRY_W-1:0] tries_inc;
    op_e              op_sel;
    logic             tmr_enable, tmr_restart, timeout;

    assign card_idx     = card_number[IDX_W-1:0];
    assign prog_tab_idx = prog_idx[IDX_W-1:0];
    assign card_ok      = {1'b0, card_number} < NUM_ACCTS_C;
    assign prog_ok      = {1'b0, prog_idx} < NUM_ACCTS_C;
    // Lock check reads the registered table, so a same-cycle program does not affect it.
    assign card_reject  = !card_ok || lock_tab_q[card_idx];
    assign psw_acc      = (state_q == ST_WAIT_PSW) && psw_valid;
    assign op_acc       = (state_q == ST_MENU) && op_valid;
    assign psw_match    = (password_input == psw_tab_q[idx_q]);
    assign tries_inc    = tries_q + TRY_W'(1);
    assign last_try     = (tries_inc == MAX_TRIES_C);
    assign op_sel       = op_e'(operation);

    assign tmr_enable  = (state_q == ST_WAIT_PSW) || (state_q == ST_MENU);
    assign tmr_restart = (state_d != state_q) || psw_acc || op_acc;

    atm_inactivity_timer #(.TMR_W(TMR_W)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .enable    (tmr_enable),
        .restart   (tmr_restart),
        .threshold (threshold),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Accepted inputs take priority over a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (card_in) state_d = card_reject ? ST_EJECT : ST_WAIT_PSW;
            end
            ST_WAIT_PSW: begin
                if (psw_acc) begin
                    if (psw_match)     state_d = ST_MENU;
                    else if (last_try) state_d = ST_EJECT;
                end else if (timeout) begin
                    state_d = ST_EJECT;
                end
            end
            ST_MENU: begin
                if (op_acc) begin
                    if (op_sel == OP_END) state_d = ST_EJECT;
                end else if (timeout) begin
                    state_d = ST_EJECT;
                end
            end
            ST_EJECT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        psw_tab_d   = psw_tab_q;
        bal_tab_d   = bal_tab_q;
        lock_tab_d  = lock_tab_q;
        idx_d       = idx_q;
        tries_d     = tries_q;
        total_d     = total_q;
        balance_d   = balance_q;
        locked_d    = locked_q;
        op_done_d   = 1'b0;
        error_d     = 1'b0;
        err_code_d  = ERR_NONE;
        wrong_psw_d = 1'b0;
        // Eject pulse coincides with the single cycle spent in EJECT.
        card_out_d  = (state_d == ST_EJECT) && (state_q != ST_EJECT);

        unique case (state_q)
            ST_IDLE: begin
                if (prog_en && prog_ok) begin
                    psw_tab_d[prog_tab_idx]  = prog_psw;
                    bal_tab_d[prog_tab_idx]  = prog_bal;
                    lock_tab_d[prog_tab_idx] = 1'b0;
                end
                if (card_in) begin
                    idx_d   = card_idx;
                    tries_d = '0;
                    if (!card_ok) begin
                        error_d    = 1'b1;
                        err_code_d = ERR_BAD_CARD;
                    end else if (lock_tab_q[card_idx]) begin
                        locked_d   = 1'b1;
                        error_d    = 1'b1;
                        err_code_d = ERR_LOCKED;
                    end
                end
            end
            ST_WAIT_PSW: begin
                if (psw_acc) begin
                    if (psw_match) begin
                        balance_d = bal_tab_q[idx_q];
                    end else begin
                        wrong_psw_d = 1'b1;
                        tries_d     = tries_inc;
                        if (last_try) begin
                            lock_tab_d[idx_q] = 1'b1;
                            locked_d          = 1'b1;
                            error_d           = 1'b1;
                            err_code_d        = ERR_LOCKED;
                        end
                    end
                end else if (timeout) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            ST_MENU: begin
                if (op_acc) begin
                    unique case (op_sel)
                        OP_INQUIRY: op_done_d = 1'b1;
                        OP_WITHDRAW: begin
                            error_d = 1'b1;
                            if (value == '0)                           err_code_d = ERR_ZERO_AMT;
                            else if (value > balance_q)                err_code_d = ERR_INSUFF;
                            else if (limit_exceeded(total_q, value))   err_code_d = ERR_LIMIT;
                            else begin
                                error_d          = 1'b0;
                                op_done_d        = 1'b1;
                                balance_d        = balance_q - value;
                                total_d          = total_q + {1'b0, value};
                                bal_tab_d[idx_q] = balance_q - value;
                            end
                        end
                        OP_DEPOSIT: begin
                            error_d = 1'b1;
                            if (value == '0)                           err_code_d = ERR_ZERO_AMT;
                            else if (add_overflows(balance_q, value))  err_code_d = ERR_OVF;
                            else begin
                                error_d          = 1'b0;
                                op_done_d        = 1'b1;
                                balance_d        = balance_q + value;
                                bal_tab_d[idx_q] = balance_q + value;
                            end
                        end
                        OP_END: ;
                        default: ;
                    endcase
                end else if (timeout) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            ST_EJECT: begin
                total_d  = '0;
                tries_d  = '0;
                locked_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACCTS; i++) begin
                psw_tab_q[i] <= '0;
                bal_tab_q[i] <= '0;
            end
            lock_tab_q  <= '0;
            idx_q       <= '0;
            tries_q     <= '0;
            total_q     <= '0;
            balance_q   <= '0;
            card_out_q  <= 1'b0;
            op_done_q   <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= '0;
            wrong_psw_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            psw_tab_q   <= psw_tab_d;
            bal_tab_q   <= bal_tab_d;
            lock_tab_q  <= lock_tab_d;
            idx_q       <= idx_d;
            tries_q     <= tries_d;
            total_q     <= total_d;
            balance_q   <= balance_d;
            card_out_q  <= card_out_d;
            op_done_q   <= op_done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            wrong_psw_q <= wrong_psw_d;
            locked_q    <= locked_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign card_out  = card_out_q;
    assign op_done   = op_done_q;
    assign balance   = balance_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
    assign wrong_psw = wrong_psw_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// -----------------------------------------------------------------------------
// tb_atm_session_ctrl
// Directed bench for atm_session_ctrl with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_atm_session_ctrl;

    localparam int CARD_W = 6;
    localparam int PSW_W  = 16;
    localparam int BAL_W  = 20;
    localparam int TMR_W  = 32;

    logic              clk;
    logic              rst;
    logic              prog_en;
    logic [CARD_W-1:0] prog_idx;
    logic [PSW_W-1:0]  prog_psw;
    logic [BAL_W-1:0]  prog_bal;
    logic              card_in;
    logic [CARD_W-1:0] card_number;
    logic              psw_valid;
    logic [PSW_W-1:0]  password_input;
    logic              op_valid;
    logic [1:0]        operation;
    logic [BAL_W-1:0]  value;
    logic [TMR_W-1:0]  threshold;
    logic              busy;
    logic              card_out;
    logic              op_done;
    logic [BAL_W-1:0]  balance;
    logic              error;
    logic [2:0]        err_code;
    logic              wrong_psw;
    logic              locked;

    int n_checks = 0;
    int n_fail   = 0;

    atm_session_ctrl #(
        .NUM_ACCTS(8), .CARD_W(CARD_W), .PSW_W(PSW_W), .BAL_W(BAL_W),
        .MAX_TRIES(3), .SESSION_LIMIT(5000), .TMR_W(TMR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .prog_en(prog_en), .prog_idx(prog_idx), .prog_psw(prog_psw), .prog_bal(prog_bal),
        .card_in(card_in), .card_number(card_number),
        .psw_valid(psw_valid), .password_input(password_input),
        .op_valid(op_valid), .operation(operation), .value(value),
        .threshold(threshold),
        .busy(busy), .card_out(card_out), .op_done(op_done), .balance(balance),
        .error(error), .err_code(err_code), .wrong_psw(wrong_psw), .locked(locked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse outputs checked together after each stimulus cycle.
    task automatic check_pulses(input string tag, input logic e_err, input logic [2:0] e_code,
                                input logic e_done, input logic e_wrong, input logic e_cout);
        check_eq({tag, ".error"},     32'(error),     32'(e_err));
        check_eq({tag, ".err_code"},  32'(err_code),  32'(e_code));
        check_eq({tag, ".op_done"},   32'(op_done),   32'(e_done));
        check_eq({tag, ".wrong_psw"}, 32'(wrong_psw), 32'(e_wrong));
        check_eq({tag, ".card_out"},  32'(card_out),  32'(e_cout));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_prog(input int idx, input int psw, input int bal);
        prog_en  = 1'b1;
        prog_idx = CARD_W'(idx);
        prog_psw = PSW_W'(psw);
        prog_bal = BAL_W'(bal);
        step();
        prog_en  = 1'b0;
    endtask

    task automatic do_card(input int num);
        card_in     = 1'b1;
        card_number = CARD_W'(num);
        step();
        card_in     = 1'b0;
    endtask

    task automatic do_psw(input int psw);
        psw_valid      = 1'b1;
        password_input = PSW_W'(psw);
        step();
        psw_valid      = 1'b0;
    endtask

    task automatic do_op(input int op, input int val);
        op_valid  = 1'b1;
        operation = 2'(op);
        value     = BAL_W'(val);
        step();
        op_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        prog_en = 1'b0; prog_idx = '0; prog_psw = '0; prog_bal = '0;
        card_in = 1'b0; card_number = '0;
        psw_valid = 1'b0; password_input = '0;
        op_valid = 1'b0; operation = '0; value = '0;
        threshold = '0;
        repeat (2) @(posedge clk);
        #1;
        check_pulses("reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check_eq("reset.busy", 32'(busy), 32'd0);
        check_eq("reset.balance", 32'(balance), 32'd0);
        check_eq("reset.locked", 32'(locked), 32'd0);
        rst = 1'b0;
        step();

        // Basic withdraw and table write-back
        do_prog(2, 'h1234, 1000);
        do_card(2);
        check_eq("t1.busy", 32'(busy), 32'd1);
        check_pulses("t1.card", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        do_psw('h1234);
        check_eq("t1.bal_load", 32'(balance), 32'd1000);
        do_op(1, 300);
        check_pulses("t1.wd", 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        check_eq("t1.bal_wd", 32'(balance), 32'd700);
        do_op(3, 0);
        check_pulses("t1.end", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("t1.idle", 32'(busy), 32'd0);
        check_eq("t1.cout_once", 32'(card_out), 32'd0);
        do_card(2);
        do_psw('h1234);
        check_eq("t1.table_700", 32'(balance), 32'd700);
        do_op(3, 0);
        step();

        // Three wrong PINs lock the account
        do_card(2);
        do_psw('h1111);
        check_pulses("t2.wrong1", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        do_op(3, 0);
        check_eq("t2.op_ignored_busy", 32'(busy), 32'd1);
        check_eq("t2.op_ignored_cout", 32'(card_out), 32'd0);
        do_psw('h2222);
        check_pulses("t2.wrong2", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        do_psw('h3333);
        check_pulses("t2.wrong3", 1'b1, 3'd2, 1'b0, 1'b1, 1'b1);
        check_eq("t2.locked", 32'(locked), 32'd1);
        step();
        check_eq("t2.locked_clr", 32'(locked), 32'd0);
        check_eq("t2.idle", 32'(busy), 32'd0);
        do_card(2);
        check_pulses("t2.reinsert", 1'b1, 3'd2, 1'b0, 1'b0, 1'b1);
        check_eq("t2.reinsert_locked", 32'(locked), 32'd1);
        step();

        // Session limit and insufficient funds
        do_prog(3, 'h0003, 10000);
        do_card(3);
        do_psw('h0003);
        do_op(1, 4000);
        check_pulses("t3.wd4000", 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        check_eq("t3.bal6000", 32'(balance), 32'd6000);
        do_op(1, 1001);
        check_pulses("t3.wd1001", 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
        check_eq("t3.bal_keep", 32'(balance), 32'd6000);
        do_op(1, 1000);
        check_pulses("t3.wd1000", 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        check_eq("t3.bal5000", 32'(balance), 32'd5000);
        do_op(1, 5001);
        check_pulses("t3.insuff", 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        do_op(1, 1);
        check_pulses("t3.limit1", 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
        check_eq("t3.still_busy", 32'(busy), 32'd1);
        do_op(3, 0);
        step();

        // Deposit overflow and zero amounts
        do_prog(4, 'h0004, 'hFFFF0);
        do_card(4);
        do_psw('h0004);
        check_eq("t4.bal_load", 32'(balance), 32'hFFFF0);
        do_op(2, 'h20);
        check_pulses("t4.ovf", 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
        check_eq("t4.bal_keep", 32'(balance), 32'hFFFF0);
        do_op(2, 'hF);
        check_pulses("t4.dep", 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        check_eq("t4.bal_max", 32'(balance), 32'hFFFFF);
        do_op(1, 0);
        check_pulses("t4.wd_zero", 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
        do_op(2, 0);
        check_pulses("t4.dep_zero", 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
        do_op(0, 0);
        check_pulses("t4.inquiry", 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        do_op(3, 0);
        step();

        // Inactivity timeout, threshold 10
        threshold = 32'd10;
        do_card(4);
        do_psw('h0004);
        repeat (9) step();
        check_pulses("t5.before_to", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        step();
        check_pulses("t5.timeout", 1'b1, 3'd6, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("t5.idle", 32'(busy), 32'd0);

        // Operation on the timeout cycle wins and restarts the timer
        do_card(4);
        do_psw('h0004);
        repeat (9) step();
        do_op(0, 0);
        check_pulses("t5.op_wins", 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        repeat (9) step();
        check_pulses("t5.restarted", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        step();
        check_pulses("t5.timeout2", 1'b1, 3'd6, 1'b0, 1'b0, 1'b1);
        step();
        threshold = '0;

        // Out-of-range card
        do_card(9);
        check_pulses("t6.bad_card", 1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
        check_eq("t6.not_locked", 32'(locked), 32'd0);
        step();
        check_eq("t6.idle", 32'(busy), 32'd0);

        // Reset in MENU: immediate idle, no eject, table cleared
        do_card(4);
        do_psw('h0004);
        check_eq("t7.menu_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("t7.rst_busy_async", 32'(busy), 32'd0);
        step();
        check_eq("t7.rst_busy", 32'(busy), 32'd0);
        check_eq("t7.rst_cout", 32'(card_out), 32'd0);
        check_eq("t7.rst_balance", 32'(balance), 32'd0);
        rst = 1'b0;
        step();
        do_card(4);
        do_psw('h0000);
        check_eq("t7.cleared_pin_ok", 32'(wrong_psw), 32'd0);
        check_eq("t7.cleared_bal", 32'(balance), 32'd0);
        check_eq("t7.cleared_busy", 32'(busy), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
